// File: rtl/memshare_regfile_loader.sv
// memshare_regfile_loader
// Write-side programmer for the memShare L1PA type-0 register file. Takes a
// valid/ready stream of shift patterns, packs each one into a page word
// {shift, delta, isGtr} and writes consecutive pages, starting at a base
// address. The base address wraps modulo PAGE_NUM. While SCU.memShare() is
// active the loader holds off, so a page is never rewritten under a read.
//
// Optional feature: define MEMSHARE_LOADER_CKSUM_EN to add cfg_cksum_i and
// cksum_err_o. The loader then sums every written page word, mod 256, and
// compares the sum with the expected checksum when the load completes.
module memshare_regfile_loader #(
  parameter int SHIFT_BITWIDTH = 3,
  parameter int DELTA_BITWIDTH = 3,
  parameter int PAGE_NUM       = 64,
  parameter int ADDR_WIDTH     = 6
) (
  input  logic                                         sys_clk,
  input  logic                                         rstn,
  input  logic                                         cfg_start_i,
  input  logic [ADDR_WIDTH-1:0]                        cfg_base_addr_i,
  input  logic [ADDR_WIDTH:0]                          cfg_len_i,
  input  logic                                         pat_valid_i,
  output logic                                         pat_ready_o,
  input  logic [SHIFT_BITWIDTH-1:0]                    pat_shift_i,
  input  logic [DELTA_BITWIDTH-1:0]                    pat_delta_i,
  input  logic                                         pat_last_i,
  input  logic                                         scu_memShare_busy_i,
  output logic [ADDR_WIDTH-1:0]                        regType0_waddr_o,
  output logic [SHIFT_BITWIDTH+DELTA_BITWIDTH:0]       regType0_wdata_o,
  output logic                                         regType0_we_o,
  output logic                                         busy_o,
  output logic                                         done_o,
  output logic                                         err_o
`ifdef MEMSHARE_LOADER_CKSUM_EN
  ,
  input  logic [7:0]                                   cfg_cksum_i,
  output logic                                         cksum_err_o
`endif
);

  localparam int PAGE_WIDTH = SHIFT_BITWIDTH + DELTA_BITWIDTH + 1;
  localparam int LEN_W      = ADDR_WIDTH + 1;
  localparam logic [LEN_W-1:0]      PAGE_NUM_L = LEN_W'(PAGE_NUM);
  localparam logic [ADDR_WIDTH-1:0] LAST_PAGE  = ADDR_WIDTH'(PAGE_NUM - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   ptr_q, ptr_d;
  logic [LEN_W-1:0]        rem_q, rem_d;
  logic                    we_q, we_d;
  logic [ADDR_WIDTH-1:0]   waddr_q, waddr_d;
  logic [PAGE_WIDTH-1:0]   wdata_q, wdata_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic                    err_q, err_d;
  logic                    hs;
  logic [PAGE_WIDTH-1:0]   page_word;
`ifdef MEMSHARE_LOADER_CKSUM_EN
  logic [7:0]              sum_q, sum_d;
  logic [7:0]              cks_cfg_q, cks_cfg_d;
  logic                    cks_err_q, cks_err_d;
`endif

  // Ready is combinational so that a rising SCU busy stalls the stream in the same cycle.
  assign pat_ready_o = (state_q == S_LOAD) && !scu_memShare_busy_i;
  assign hs          = pat_valid_i && pat_ready_o;
  assign page_word   = {pat_shift_i, pat_delta_i, pat_last_i};

  // Next-state, pointer/counter and registered write-port values.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    rem_d   = rem_q;
    we_d    = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    done_d  = 1'b0;
    err_d   = err_q;
`ifdef MEMSHARE_LOADER_CKSUM_EN
    sum_d     = sum_q;
    cks_cfg_d = cks_cfg_q;
    cks_err_d = cks_err_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (cfg_start_i) begin
          ptr_d = cfg_base_addr_i;
          // Oversized lengths are flagged and clamped to the full page count.
          err_d = (cfg_len_i > PAGE_NUM_L);
          rem_d = (cfg_len_i > PAGE_NUM_L) ? PAGE_NUM_L : cfg_len_i;
`ifdef MEMSHARE_LOADER_CKSUM_EN
          sum_d     = 8'd0;
          cks_cfg_d = cfg_cksum_i;
          cks_err_d = 1'b0;
`endif
          if (cfg_len_i == '0) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end else begin
            state_d = S_LOAD;
          end
        end
      end
      S_LOAD: begin
        if (cfg_start_i) err_d = 1'b1;
        if (hs) begin
          we_d    = 1'b1;
          waddr_d = ptr_q;
          wdata_d = page_word;
          ptr_d   = (ptr_q == LAST_PAGE) ? '0 : ptr_q + ADDR_WIDTH'(1);
          rem_d   = rem_q - LEN_W'(1);
`ifdef MEMSHARE_LOADER_CKSUM_EN
          sum_d   = sum_q + 8'(page_word);
`endif
          if (rem_q == LEN_W'(1)) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end
        end
      end
      S_DONE: begin
        if (cfg_start_i) err_d = 1'b1;
`ifdef MEMSHARE_LOADER_CKSUM_EN
        cks_err_d = (sum_q != cks_cfg_q);
`endif
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge sys_clk) begin
    if (!rstn) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      rem_q   <= '0;
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
`ifdef MEMSHARE_LOADER_CKSUM_EN
      sum_q     <= 8'd0;
      cks_cfg_q <= 8'd0;
      cks_err_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      rem_q   <= rem_d;
      we_q    <= we_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
`ifdef MEMSHARE_LOADER_CKSUM_EN
      sum_q     <= sum_d;
      cks_cfg_q <= cks_cfg_d;
      cks_err_q <= cks_err_d;
`endif
    end
  end

  assign regType0_we_o    = we_q;
  assign regType0_waddr_o = waddr_q;
  assign regType0_wdata_o = wdata_q;
  assign busy_o           = busy_q;
  assign done_o           = done_q;
  assign err_o            = err_q;
`ifdef MEMSHARE_LOADER_CKSUM_EN
  assign cksum_err_o      = cks_err_q;
`endif

endmodule

// File: tb/tb_memshare_regfile_loader.sv
// Testbench for memshare_regfile_loader: directed scenarios plus randomized
// loads, checked every cycle against a behavioural model of the loader.
`timescale 1ns/1ps
module tb_memshare_regfile_loader;
  localparam int AW = 6;
  localparam int PN = 64;

  logic          sys_clk = 1'b0;
  logic          rstn;
  logic          cfg_start_i;
  logic [AW-1:0] cfg_base_addr_i;
  logic [AW:0]   cfg_len_i;
  logic          pat_valid_i;
  logic          pat_ready_o;
  logic [2:0]    pat_shift_i;
  logic [2:0]    pat_delta_i;
  logic          pat_last_i;
  logic          scu_memShare_busy_i;
  logic [AW-1:0] regType0_waddr_o;
  logic [6:0]    regType0_wdata_o;
  logic          regType0_we_o;
  logic          busy_o;
  logic          done_o;
  logic          err_o;
`ifdef MEMSHARE_LOADER_CKSUM_EN
  logic [7:0]    cfg_cksum_i;
  logic          cksum_err_o;
`endif

  always #5 sys_clk = ~sys_clk;

  memshare_regfile_loader dut (
    .sys_clk             (sys_clk),
    .rstn                (rstn),
    .cfg_start_i         (cfg_start_i),
    .cfg_base_addr_i     (cfg_base_addr_i),
    .cfg_len_i           (cfg_len_i),
    .pat_valid_i         (pat_valid_i),
    .pat_ready_o         (pat_ready_o),
    .pat_shift_i         (pat_shift_i),
    .pat_delta_i         (pat_delta_i),
    .pat_last_i          (pat_last_i),
    .scu_memShare_busy_i (scu_memShare_busy_i),
    .regType0_waddr_o    (regType0_waddr_o),
    .regType0_wdata_o    (regType0_wdata_o),
    .regType0_we_o       (regType0_we_o),
    .busy_o              (busy_o),
    .done_o              (done_o),
    .err_o               (err_o)
`ifdef MEMSHARE_LOADER_CKSUM_EN
    ,
    .cfg_cksum_i         (cfg_cksum_i),
    .cksum_err_o         (cksum_err_o)
`endif
  );

  int total = 0;
  int bad   = 0;

  // staged inputs for the next cycle
  bit         d_rstn, d_start, d_valid, d_scu;
  logic [5:0] d_base;
  logic [6:0] d_len;
  logic [7:0] d_cks;
  logic [6:0] d_beat;

  // behavioural model: a load is "k of total beats accepted"
  bit         m_loading, m_busy, m_we, m_done, m_err, m_cks_err;
  int         m_total, m_k, m_base, m_sum;
  logic [5:0] m_waddr;
  logic [6:0] m_wdata;
  logic [7:0] m_cks;
  bit         last_hs, chk_en;
  int         n_writes;
  logic [6:0] beat_q[$];

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h at %0t", tag, act, exp, $time);
    end
  endtask

  // One clock cycle: check registered outputs, apply staged inputs, check ready, advance model.
  task automatic step();
    bit exp_ready, hs, new_we, new_done;
    @(negedge sys_clk);
    if (chk_en) begin
      check("we", regType0_we_o, m_we);
      if (m_we) begin
        check("waddr", regType0_waddr_o, m_waddr);
        check("wdata", regType0_wdata_o, m_wdata);
      end
      check("done", done_o, m_done);
      check("busy", busy_o, m_busy);
      check("err", err_o, m_err);
`ifdef MEMSHARE_LOADER_CKSUM_EN
      check("cksum_err", cksum_err_o, m_cks_err);
`endif
    end
    if (regType0_we_o === 1'b1) n_writes++;
    rstn                = d_rstn;
    cfg_start_i         = d_start;
    cfg_base_addr_i     = d_base;
    cfg_len_i           = d_len;
    pat_valid_i         = d_valid;
    pat_shift_i         = d_beat[6:4];
    pat_delta_i         = d_beat[3:1];
    pat_last_i          = d_beat[0];
    scu_memShare_busy_i = d_scu;
`ifdef MEMSHARE_LOADER_CKSUM_EN
    cfg_cksum_i         = d_cks;
`endif
    #1;
    exp_ready = m_loading && !d_scu;
    if (chk_en) check("ready", pat_ready_o, exp_ready);
    hs = d_valid && exp_ready && d_rstn;
    @(posedge sys_clk);
    if (!d_rstn) begin
      m_loading = 0; m_busy = 0; m_we = 0; m_done = 0; m_err = 0; m_cks_err = 0;
      m_total = 0; m_k = 0; m_sum = 0; m_cks = 0;
      hs = 0;
    end else begin
      new_we = 0; new_done = 0;
      if (m_done) m_cks_err = (m_sum[7:0] != m_cks);
      if (d_start) begin
        if (m_busy) m_err = 1;
        else begin
          m_err     = (int'(d_len) > PN);
          m_total   = (int'(d_len) > PN) ? PN : int'(d_len);
          m_k       = 0;
          m_base    = int'(d_base);
          m_sum     = 0;
          m_cks     = d_cks;
          m_cks_err = 0;
          if (m_total == 0) new_done = 1;
          else m_loading = 1;
        end
      end
      if (hs) begin
        new_we  = 1;
        m_waddr = 6'((m_base + m_k) % PN);
        m_wdata = d_beat;
        m_sum   = (m_sum + int'(d_beat)) % 256;
        m_k++;
        if (m_k == m_total) begin
          m_loading = 0;
          new_done  = 1;
        end
      end
      m_we   = new_we;
      m_done = new_done;
      m_busy = m_loading || new_done;
    end
    last_hs = hs;
    d_start = 0;
    d_rstn  = 1;
  endtask

  function automatic logic [6:0] next_beat();
    logic [6:0] b;
    if (beat_q.size() > 0) b = beat_q.pop_front();
    else b = 7'($urandom);
    return b;
  endfunction

  // scu_mode: 0 never busy, 1 random, 2 busy for 3 cycles after 2nd beat.
  task automatic run_load(input int base, input int len, input logic [7:0] cks, input int scu_mode,
                          input bit inject, input int rst_after, input bit b2b, input int exp_n);
    int guard, scu_left;
    bit scu_fired;
    logic [6:0] cur;
    n_writes = 0;
    d_base = 6'(base); d_len = 7'(len); d_cks = cks; d_start = 1; d_valid = 0; d_scu = 0;
    step();
    cur = next_beat();
    guard = 0; scu_left = 0; scu_fired = 0;
    while (m_loading && guard < 3000) begin
      guard++;
      d_valid = b2b ? 1'b1 : ($urandom_range(0, 3) != 0);
      d_beat  = cur;
      case (scu_mode)
        1: d_scu = ($urandom_range(0, 3) == 0);
        2: begin
          if (m_k == 2 && !scu_fired) begin scu_left = 3; scu_fired = 1; end
          d_scu = (scu_left > 0);
          if (scu_left > 0) scu_left--;
        end
        default: d_scu = 0;
      endcase
      if (inject && guard == 3) begin
        d_start = 1; d_base = 6'(base + 7); d_len = 7'd2;
      end
      if (rst_after > 0 && m_k == rst_after) begin
        d_rstn = 0; d_valid = 0;
        step();
        break;
      end
      step();
      if (last_hs) cur = next_beat();
    end
    if (m_loading) begin
      total++; bad++;
      $display("FAIL load_timeout: got=loading want=idle");
    end
    d_valid = 0; d_scu = 0;
    step();
    step();
    check("nwrites", n_writes, exp_n);
  endtask

  initial begin
    rstn = 0; cfg_start_i = 0; cfg_base_addr_i = 0; cfg_len_i = 0; pat_valid_i = 0;
    pat_shift_i = 0; pat_delta_i = 0; pat_last_i = 0; scu_memShare_busy_i = 0;
`ifdef MEMSHARE_LOADER_CKSUM_EN
    cfg_cksum_i = 0;
`endif
    d_rstn = 0; d_start = 0; d_valid = 0; d_scu = 0; d_base = 0; d_len = 0; d_cks = 0; d_beat = 0;
    chk_en = 0;
    step();
    d_rstn = 0;
    step();
    chk_en = 1;
    step();
    check("rst_we", regType0_we_o, 0);
    check("rst_busy", busy_o, 0);
    check("rst_waddr", regType0_waddr_o, 0);
    check("rst_wdata", regType0_wdata_o, 0);

    // 1) three back-to-back beats, correct then wrong checksum
    beat_q = '{7'h22, 7'h50, 7'h35};
    run_load(0, 3, 8'hA7, 0, 0, 0, 1, 3);
`ifdef MEMSHARE_LOADER_CKSUM_EN
    check("cksum_ok", cksum_err_o, 0);
`endif
    beat_q = '{7'h22, 7'h50, 7'h35};
    run_load(0, 3, 8'hA6, 0, 0, 0, 1, 3);
`ifdef MEMSHARE_LOADER_CKSUM_EN
    check("cksum_bad", cksum_err_o, 1);
`endif

    // 2) wrap from page 63 to page 0
    run_load(62, 4, 8'h00, 0, 0, 0, 1, 4);

    // 3) SCU busy stall after the second beat
    run_load(20, 5, 8'h00, 2, 0, 0, 1, 5);

    // 4) start while loading, then oversized length
    run_load(5, 6, 8'h00, 0, 1, 0, 1, 6);
    check("err_sticky", err_o, 1);
    run_load(40, 65, 8'h00, 1, 0, 0, 0, 64);
    check("err_len", err_o, 1);
    run_load(3, 2, 8'h00, 0, 0, 0, 1, 2);
    check("err_clear", err_o, 0);

    // 5) reset after 2 of 4 beats, then a fresh load from page 10
    run_load(30, 4, 8'h00, 0, 0, 2, 1, 2);
    check("rst_mid_busy", busy_o, 0);
    run_load(10, 4, 8'h00, 1, 0, 0, 0, 4);

    // 6) zero-length load
    run_load(12, 0, 8'h00, 0, 0, 0, 0, 0);

    // randomized loads
    for (int i = 0; i < 12; i++) begin
      int len;
      len = $urandom_range(0, 70);
      run_load($urandom_range(0, 63), len, 8'($urandom), 1, 0, 0, 0, (len > PN) ? PN : len);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
